// File: rtl/tpu_operand_bank_if.sv
// Host-side write/commit handshake for tpu_operand_bank.
// The master is the host (plus the array's busy flag); the slave is the operand bank.
interface tpu_operand_bank_if #(
  parameter int DIM    = 2,
  parameter int DATA_W = 8
);
  localparam int NumElem = 2 * DIM * DIM;
  localparam int ADDR_W  = ($clog2(NumElem) < 1) ? 1 : $clog2(NumElem);

  logic              wr_valid;
  logic              wr_ready;
  logic              wr_auto;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              commit;
  logic              busy;
  logic              commit_done;

  modport master (
    output wr_valid, wr_auto, wr_addr, wr_data, commit, busy,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_auto, wr_addr, wr_data, commit, busy,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/tpu_operand_bank.sv
// Double-buffered DIM x DIM weights/inputs store; host fills the shadow bank, commit swaps banks.
// Optional shadow-bank readback port when TPU_OPERAND_READBACK_EN is defined.
module tpu_operand_bank #(
  parameter int DIM       = 2,
  parameter int DATA_W    = 8,
  localparam int NumElem  = 2 * DIM * DIM,
  localparam int ADDR_W   = ($clog2(NumElem) < 1) ? 1 : $clog2(NumElem)
) (
  input  logic                         clk,
  input  logic                         rst,
  tpu_operand_bank_if.slave            bus,
  output logic                         bank_sel,
  output logic                         shadow_full,
  output logic                         addr_err,
  output logic [DIM*DIM*DATA_W-1:0]    weights_flat,
  output logic [DIM*DIM*DATA_W-1:0]    inputs_flat
`ifdef TPU_OPERAND_READBACK_EN
  ,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid
`endif
);

  localparam int                Half     = DIM * DIM;
  localparam logic [ADDR_W:0]   NumElemW = (ADDR_W + 1)'(NumElem);
  localparam logic [ADDR_W-1:0] PtrLast  = ADDR_W'(NumElem - 1);
  localparam logic              StFill    = 1'b0;
  localparam logic              StPending = 1'b1;

  logic                state_q, state_d;
  logic                bank_sel_q;
  logic                commit_done_q;
  logic                shadow_full_q;
  logic                addr_err_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [NumElem-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]   mem_q [2][NumElem];

  logic                wr_fire;
  logic                in_range;
  logic                swap;
  logic [ADDR_W-1:0]   eff_addr;

  always_comb begin
    wr_fire  = bus.wr_valid && (state_q == StFill);
    eff_addr = bus.wr_auto ? ptr_q : bus.wr_addr;
    in_range = {1'b0, eff_addr} < NumElemW;
    swap     = (state_q == StPending) && !bus.busy;

    state_d = state_q;
    if (state_q == StFill && bus.commit) state_d = StPending;
    if (swap)                            state_d = StFill;

    ptr_d = ptr_q;
    if (wr_fire && bus.wr_auto) ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + ADDR_W'(1);
    if (swap)                   ptr_d = '0;

    mask_d = mask_q;
    if (wr_fire && in_range) mask_d[eff_addr] = 1'b1;
    if (swap)                mask_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFill;
      bank_sel_q    <= 1'b0;
      commit_done_q <= 1'b0;
      shadow_full_q <= 1'b0;
      addr_err_q    <= 1'b0;
      ptr_q         <= '0;
      mask_q        <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NumElem; i++) mem_q[b][i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      mask_q        <= mask_d;
      commit_done_q <= swap;
      shadow_full_q <= &mask_d;
      if (swap) bank_sel_q <= ~bank_sel_q;
      // Out-of-range writes still complete the handshake; only the store is dropped.
      if (wr_fire && !in_range) addr_err_q <= 1'b1;
      if (wr_fire && in_range)  mem_q[~bank_sel_q][eff_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    weights_flat = '0;
    inputs_flat  = '0;
    for (int k = 0; k < Half; k++) begin
      weights_flat[k*DATA_W +: DATA_W] = mem_q[bank_sel_q][k];
      inputs_flat[k*DATA_W +: DATA_W]  = mem_q[bank_sel_q][Half + k];
    end
  end

  assign bus.wr_ready    = (state_q == StFill);
  assign bus.commit_done = commit_done_q;
  assign bank_sel        = bank_sel_q;
  assign shadow_full     = shadow_full_q;
  assign addr_err        = addr_err_q;

`ifdef TPU_OPERAND_READBACK_EN
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_range;

  assign rd_range = {1'b0, rd_addr} < NumElemW;

  // Reads see the pre-edge contents, so a same-cycle write to the same address returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_range ? mem_q[~bank_sel_q][rd_addr] : '0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_tpu_operand_bank.sv
// Scoreboard bench for tpu_operand_bank: expected swap results are queued at commit time and
// checked by a monitor whenever commit_done (or rd_valid) is presented.
module tb_tpu_operand_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tpu_operand_bank_if #(.DIM(2), .DATA_W(8)) bus ();
  tpu_operand_bank_if #(.DIM(3), .DATA_W(8)) bus3 ();

  logic        bank_sel, shadow_full, addr_err;
  logic [31:0] weights_flat, inputs_flat;
  logic        bank_sel3, shadow_full3, addr_err3;
  logic [71:0] weights3, inputs3;

`ifdef TPU_OPERAND_READBACK_EN
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_en3 = 1'b0;
  logic [4:0] rd_addr3 = '0;
  logic [7:0] rd_data3;
  logic       rd_valid3;
`endif

  tpu_operand_bank #(.DIM(2), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .bank_sel     (bank_sel),
    .shadow_full  (shadow_full),
    .addr_err     (addr_err),
    .weights_flat (weights_flat),
    .inputs_flat  (inputs_flat)
`ifdef TPU_OPERAND_READBACK_EN
    ,
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid)
`endif
  );

  tpu_operand_bank #(.DIM(3), .DATA_W(8)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus3),
    .bank_sel     (bank_sel3),
    .shadow_full  (shadow_full3),
    .addr_err     (addr_err3),
    .weights_flat (weights3),
    .inputs_flat  (inputs3)
`ifdef TPU_OPERAND_READBACK_EN
    ,
    .rd_en        (rd_en3),
    .rd_addr      (rd_addr3),
    .rd_data      (rd_data3),
    .rd_valid     (rd_valid3)
`endif
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] inp;
    logic        sel;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : commit_mon
    exp_t e;
    if (!rst && bus.commit_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit_done", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("swap_weights", weights_flat, e.w);
        check("swap_inputs", inputs_flat, e.inp);
        check("swap_bank_sel", bank_sel, e.sel);
        check("swap_cycle", cyc, e.at);
      end
    end
  end

`ifdef TPU_OPERAND_READBACK_EN
  typedef struct {
    logic [7:0] data;
    int         at;
  } rd_exp_t;

  rd_exp_t rd_q[$];

  always @(negedge clk) begin : rd_mon
    rd_exp_t r;
    if (!rst && rd_valid) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rd_valid", rd_q.size(), 1);
      end else begin
        r = rd_q.pop_front();
        check("rd_data", rd_data, r.data);
        check("rd_cycle", cyc, r.at);
      end
    end
  end
`endif

  task automatic wr(input logic auto_mode, input logic [2:0] addr, input logic [7:0] data);
    int n;
    bus.wr_valid = 1'b1;
    bus.wr_auto  = auto_mode;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    n = 0;
    while (bus.wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("wr_ready", bus.wr_ready, 1'b1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_commit(input int busy_cycles, input logic [31:0] w, input logic [31:0] inp,
                           input logic sel);
    logic [31:0] w_old;
    exp_t        e;
    int          n;
    w_old      = weights_flat;
    bus.commit = 1'b1;
    bus.busy   = (busy_cycles > 0);
    e.w   = w;
    e.inp = inp;
    e.sel = sel;
    e.at  = cyc + 2 + busy_cycles;
    exp_q.push_back(e);
    tick();
    bus.commit = 1'b0;
    for (int i = 0; i < busy_cycles; i++) begin
      check("busy_wr_ready", bus.wr_ready, 1'b0);
      check("busy_hold", weights_flat, w_old);
      tick();
    end
    bus.busy = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check("commit_done_seen", exp_q.size(), 0);
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
    $fatal(1);
  end

  initial begin : stim
    int n;
    bus.wr_valid  = 1'b0;
    bus.wr_auto   = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.commit    = 1'b0;
    bus.busy      = 1'b0;
    bus3.wr_valid = 1'b0;
    bus3.wr_auto  = 1'b0;
    bus3.wr_addr  = '0;
    bus3.wr_data  = '0;
    bus3.commit   = 1'b0;
    bus3.busy     = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_weights", weights_flat, 32'h0);
    check("rst_inputs", inputs_flat, 32'h0);
    check("rst_bank_sel", bank_sel, 1'b0);
    check("rst_wr_ready", bus.wr_ready, 1'b1);
    check("rst_shadow_full", shadow_full, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);

    // Full auto fill then immediate swap.
    for (int i = 0; i < 8; i++) begin
      wr(1'b1, 3'd0, 8'((i + 1) * 8'h11));
      if (i == 6) check("shadow_full_7of8", shadow_full, 1'b0);
    end
    check("shadow_full_8of8", shadow_full, 1'b1);
    check("active_untouched", weights_flat, 32'h0);
    do_commit(0, 32'h44332211, 32'h88776655, 1'b1);
    check("shadow_full_after_swap", shadow_full, 1'b0);

    // Swap held off by busy.
    for (int i = 0; i < 8; i++) wr(1'b1, 3'd0, 8'(i + 1));
    do_commit(5, 32'h04030201, 32'h08070605, 1'b0);

    // Partial update: shadow is the old active bank.
    wr(1'b0, 3'd5, 8'hAB);
    check("shadow_full_partial", shadow_full, 1'b0);
    do_commit(0, 32'h44332211, 32'h8877AB55, 1'b1);

    // Manual write mid-stream must not move the pointer; pointer wraps after 8.
    wr(1'b1, 3'd0, 8'hA0);
    wr(1'b0, 3'd3, 8'h5C);
    wr(1'b1, 3'd0, 8'hA1);
    for (int i = 2; i <= 8; i++) wr(1'b1, 3'd0, 8'(8'hA0 + i));
    check("shadow_full_wrap", shadow_full, 1'b1);
    do_commit(0, 32'hA3A2A1A8, 32'hA7A6A5A4, 1'b0);

    // Out-of-range write on the DIM=3 instance (18 elements, 5-bit address).
    bus3.wr_valid = 1'b1;
    bus3.wr_auto  = 1'b0;
    bus3.wr_addr  = 5'd20;
    bus3.wr_data  = 8'hEE;
    check("oor_wr_ready", bus3.wr_ready, 1'b1);
    tick();
    bus3.wr_valid = 1'b0;
    check("oor_addr_err", addr_err3, 1'b1);
    check("main_addr_err_clear", addr_err, 1'b0);
    bus3.wr_valid = 1'b1;
    bus3.wr_auto  = 1'b1;
    bus3.wr_data  = 8'h77;
    tick();
    bus3.wr_valid = 1'b0;
    bus3.commit   = 1'b1;
    tick();
    bus3.commit = 1'b0;
    n = 0;
    while (bus3.commit_done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("oor_commit_done", bus3.commit_done, 1'b1);
    check("oor_weights", weights3, 72'h77);
    check("oor_inputs", inputs3, 72'h0);
    check("oor_addr_err_sticky", addr_err3, 1'b1);

    // Reset while pending aborts the swap.
    wr(1'b1, 3'd0, 8'h99);
    bus.commit = 1'b1;
    bus.busy   = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    check("pending_wr_ready", bus.wr_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    bus.busy = 1'b0;
    tick();
    tick();
    check("abort_weights", weights_flat, 32'h0);
    check("abort_inputs", inputs_flat, 32'h0);
    check("abort_bank_sel", bank_sel, 1'b0);
    check("abort_shadow_full", shadow_full, 1'b0);
    check("abort_wr_ready", bus.wr_ready, 1'b1);
    check("abort_addr_err3", addr_err3, 1'b0);

`ifdef TPU_OPERAND_READBACK_EN
    begin
      rd_exp_t r;
      wr(1'b0, 3'd0, 8'h5A);
      rd_en   = 1'b1;
      rd_addr = 3'd0;
      r.data  = 8'h5A;
      r.at    = cyc + 1;
      rd_q.push_back(r);
      tick();
      // Read and write of the same address in one cycle returns old contents.
      rd_addr       = 3'd1;
      r.data        = 8'h00;
      r.at          = cyc + 1;
      rd_q.push_back(r);
      bus.wr_valid  = 1'b1;
      bus.wr_auto   = 1'b0;
      bus.wr_addr   = 3'd1;
      bus.wr_data   = 8'h66;
      tick();
      bus.wr_valid  = 1'b0;
      r.data        = 8'h66;
      r.at          = cyc + 1;
      rd_q.push_back(r);
      tick();
      rd_en = 1'b0;
      n = 0;
      while (rd_q.size() != 0 && n < 10) begin
        tick();
        n++;
      end
      check("rd_all_seen", rd_q.size(), 0);
    end
`endif

    repeat (3) tick();
    check("no_pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
